// File: rtl/jtag_ir_param_if.sv
// TAP-side control and IR-side result bundle for the parametrised JTAG IR.
// The master modport is the TAP controller; the slave modport is the IR.
interface jtag_ir_param_if #(
  parameter int IR_WIDTH = 4
);
  // Keep the status bus at least one bit wide so a 2-bit IR still elaborates.
  localparam int SW = (IR_WIDTH > 2) ? IR_WIDTH - 2 : 1;

  logic                test_logic_reset;
  logic                capture_ir;
  logic                shift_ir;
  logic                update_ir;
  logic                tdi;
  logic [SW-1:0]       status_in;
  logic                tdo;
  logic                tdo_en;
  logic [IR_WIDTH-1:0] instr;
  logic                sel_extest;
  logic                sel_sample;
  logic                sel_idcode;
  logic                sel_bypass;
  logic                update_done;

  modport master (
    output test_logic_reset, capture_ir, shift_ir, update_ir, tdi, status_in,
    input  tdo, tdo_en, instr, sel_extest, sel_sample, sel_idcode, sel_bypass,
           update_done
  );

  modport slave (
    input  test_logic_reset, capture_ir, shift_ir, update_ir, tdi, status_in,
    output tdo, tdo_en, instr, sel_extest, sel_sample, sel_idcode, sel_bypass,
           update_done
  );
endinterface

// File: rtl/jtag_ir_param.sv
// Parametrised JTAG instruction register: shift stage, update stage and registered one-hot decode.
// Controls take effect on the rising clock edge; tdo is combinational from the shift stage LSB.
module jtag_ir_param #(
  parameter int                  IR_WIDTH    = 4,
  parameter logic [IR_WIDTH-1:0] RESET_INSTR = 4'b0010,
  parameter logic [IR_WIDTH-1:0] OPC_EXTEST  = 4'b0000,
  parameter logic [IR_WIDTH-1:0] OPC_SAMPLE  = 4'b0001,
  parameter logic [IR_WIDTH-1:0] OPC_IDCODE  = 4'b0010
) (
  input logic             clock,
  input logic             reset,
  jtag_ir_param_if.slave  ir
);

  localparam logic [IR_WIDTH-1:0] SR_RESET = IR_WIDTH'(1);

  logic [IR_WIDTH-1:0] sr;
  logic [IR_WIDTH-1:0] instr_q;
  logic [3:0]          sel_q;   // {bypass, idcode, sample, extest}
  logic                tdo_en_q;
  logic                update_done_q;
  logic [IR_WIDTH-1:0] cap_val;

  generate
    if (IR_WIDTH > 2) begin : g_status
      assign cap_val = {ir.status_in[IR_WIDTH-3:0], 2'b01};
    end else begin : g_no_status
      assign cap_val = SR_RESET;
    end
  endgenerate

  // All-ones is always BYPASS; among colliding opcodes extest wins over sample over idcode.
  function automatic logic [3:0] decode(input logic [IR_WIDTH-1:0] v);
    logic [3:0] s;
    s = 4'b1000;
    if (!(&v)) begin
      if (v == OPC_EXTEST)      s = 4'b0001;
      else if (v == OPC_SAMPLE) s = 4'b0010;
      else if (v == OPC_IDCODE) s = 4'b0100;
    end
    return s;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr            <= SR_RESET;
      instr_q       <= RESET_INSTR;
      sel_q         <= decode(RESET_INSTR);
      tdo_en_q      <= 1'b0;
      update_done_q <= 1'b0;
    end else if (ir.test_logic_reset) begin
      sr            <= SR_RESET;
      instr_q       <= RESET_INSTR;
      sel_q         <= decode(RESET_INSTR);
      tdo_en_q      <= 1'b0;
      update_done_q <= 1'b0;
    end else begin
      tdo_en_q      <= ir.shift_ir;
      update_done_q <= 1'b0;
      if (ir.capture_ir) begin
        sr <= cap_val;
      end else if (ir.shift_ir) begin
        sr <= {ir.tdi, sr[IR_WIDTH-1:1]};
      end else if (ir.update_ir) begin
        // Decode the incoming value so selects move together with instr.
        instr_q       <= sr;
        sel_q         <= decode(sr);
        update_done_q <= 1'b1;
      end
    end
  end

  assign ir.tdo         = sr[0];
  assign ir.tdo_en      = tdo_en_q;
  assign ir.instr       = instr_q;
  assign ir.sel_extest  = sel_q[0];
  assign ir.sel_sample  = sel_q[1];
  assign ir.sel_idcode  = sel_q[2];
  assign ir.sel_bypass  = sel_q[3];
  assign ir.update_done = update_done_q;

endmodule

// File: tb/tb_jtag_ir_param.sv
// Randomised and directed bench for jtag_ir_param (IR_WIDTH=4) against a queue-based IR model.
module tb_jtag_ir_param;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  jtag_ir_param_if #(.IR_WIDTH(4)) bus ();

  jtag_ir_param #(.IR_WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .ir    (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  // Model: q[0] is the bit presented on tdo, q[3] is the MSB where tdi enters.
  bit q[$];
  int m_instr;
  bit m_tdo_en;
  bit m_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_load(input bit b0, input bit b1, input bit b2, input bit b3);
    q.delete();
    q.push_back(b0); q.push_back(b1); q.push_back(b2); q.push_back(b3);
  endtask

  task automatic model_reset();
    model_load(1'b1, 1'b0, 1'b0, 1'b0);
    m_instr  = 2;
    m_tdo_en = 1'b0;
    m_done   = 1'b0;
  endtask

  function automatic int model_sr();
    int v = 0;
    for (int i = 0; i < 4; i++) if (q[i]) v += (1 << i);
    return v;
  endfunction

  task automatic model_step(input bit tlr, input bit cap, input bit sh, input bit upd,
                            input bit t, input logic [1:0] st);
    if (tlr) begin
      model_reset();
    end else begin
      m_tdo_en = sh;
      m_done   = 1'b0;
      if (cap) begin
        model_load(1'b1, 1'b0, st[0], st[1]);
      end else if (sh) begin
        void'(q.pop_front());
        q.push_back(t);
      end else if (upd) begin
        m_instr = model_sr();
        m_done  = 1'b1;
      end
    end
  endtask

  // Drive one clock cycle of controls; returns 1 time unit after the edge.
  task automatic cycle(input bit tlr, input bit cap, input bit sh, input bit upd,
                       input bit t, input logic [1:0] st);
    bus.test_logic_reset = tlr;
    bus.capture_ir       = cap;
    bus.shift_ir         = sh;
    bus.update_ir        = upd;
    bus.tdi              = t;
    bus.status_in        = st;
    @(posedge clock);
    model_step(tlr, cap, sh, upd, t, st);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic shift_bit(input bit t);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, t, 2'b00);
  endtask

  task automatic update();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
  endtask

  // Asynchronous reset applied between edges; effects must be visible before any edge.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #2;
    chk("async_rst_instr", int'(bus.instr), 2);
    chk("async_rst_idcode", int'(bus.sel_idcode), 1);
    chk("async_rst_tdo", int'(bus.tdo), 1);
    chk("async_rst_tdo_en", int'(bus.tdo_en), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  function automatic bit exp_sel(input int v, input int which);
    bit ext, smp, idc;
    ext = (v == 0);
    smp = (v == 1);
    idc = (v == 2);
    case (which)
      0: return ext;
      1: return smp;
      2: return idc;
      default: return !(ext || smp || idc);
    endcase
  endfunction

  always @(negedge clock) begin
    if (run) begin
      chk("tdo", int'(bus.tdo), int'(q[0]));
      chk("tdo_en", int'(bus.tdo_en), int'(m_tdo_en));
      chk("instr", int'(bus.instr), m_instr);
      chk("update_done", int'(bus.update_done), int'(m_done));
      chk("sel_extest", int'(bus.sel_extest), int'(exp_sel(m_instr, 0)));
      chk("sel_sample", int'(bus.sel_sample), int'(exp_sel(m_instr, 1)));
      chk("sel_idcode", int'(bus.sel_idcode), int'(exp_sel(m_instr, 2)));
      chk("sel_bypass", int'(bus.sel_bypass), int'(exp_sel(m_instr, 3)));
      chk("sel_onehot", int'(bus.sel_extest) + int'(bus.sel_sample) +
                        int'(bus.sel_idcode) + int'(bus.sel_bypass), 1);
    end
  end

  logic [3:0] shift_in;
  bit         tdo_seq [4];
  bit         tdo_exp [4];

  initial begin
    bus.test_logic_reset = 1'b0;
    bus.capture_ir       = 1'b0;
    bus.shift_ir         = 1'b0;
    bus.update_ir        = 1'b0;
    bus.tdi              = 1'b0;
    bus.status_in        = 2'b00;
    model_reset();
    run = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle();
    do_reset();
    idle();

    // Capture with status 2'b10, then shift ones: tdo must read 1,0,0,1.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
    chk("capture_sr", model_sr(), 9);
    tdo_exp = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      tdo_seq[i] = bus.tdo;
      shift_bit(1'b1);
    end
    for (int i = 0; i < 4; i++) chk("capture_tdo_seq", int'(tdo_seq[i]), int'(tdo_exp[i]));
    update();
    chk("upd_ones_instr", int'(bus.instr), 15);
    chk("upd_ones_bypass", int'(bus.sel_bypass), 1);
    chk("upd_ones_done", int'(bus.update_done), 1);
    idle();
    chk("upd_ones_done_clr", int'(bus.update_done), 0);

    // EXTEST
    for (int i = 0; i < 4; i++) shift_bit(1'b0);
    update();
    chk("extest_instr", int'(bus.instr), 0);
    chk("extest_sel", int'(bus.sel_extest), 1);
    idle();

    // Unlisted opcode 4'b0101
    shift_in = 4'b0101;
    for (int i = 0; i < 4; i++) shift_bit(shift_in[i]);
    update();
    chk("unlisted_instr", int'(bus.instr), 5);
    chk("unlisted_bypass", int'(bus.sel_bypass), 1);
    idle();

    // Over-shift: last four of 0,1,0,0,1,1 give 4'b1100
    shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b0);
    shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1);
    update();
    chk("overshift_instr", int'(bus.instr), 12);
    idle();

    // Repeat update with no shift reloads the same value and still pulses.
    update();
    chk("reupdate_instr", int'(bus.instr), 12);
    chk("reupdate_done", int'(bus.update_done), 1);
    idle();

    // test_logic_reset beats update_ir after loading SAMPLE
    shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    chk("tlr_instr", int'(bus.instr), 2);
    chk("tlr_no_done", int'(bus.update_done), 0);
    chk("tlr_idcode", int'(bus.sel_idcode), 1);
    idle();
    chk("tlr_no_done_late", int'(bus.update_done), 0);

    // Async reset mid-shift after two bits discards the partial instruction.
    shift_bit(1'b0); shift_bit(1'b0);
    do_reset();
    chk("midshift_sr", model_sr(), 1);
    for (int i = 0; i < 4; i++) shift_bit(1'b0);
    update();
    chk("midshift_after_instr", int'(bus.instr), 0);
    idle();

    // Randomised control mix, including illegal overlaps and rare resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
              $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
      end
    end
    idle();
    @(negedge clock);
    #1;
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
